serializer: RTL and testbench

- Multi-bit parallel-to-serial converter; the transmit-side counterpart of the team's multi-bit deserializer.
- Accepts a frame of PARL_WIDTH words of DATA_WIDTH bits through a valid/ready load handshake.
- Emits one word per clock on `ser`, qualified by `ser_en`; `ser_en` drives the deserializer `en` directly.
- Supports MSB/LSB word order via `dir` and gapless back-to-back frames (stream mode).

---
 rtl/serializer_if.sv | 24 ++
 rtl/serializer.sv | 144 ++++++++++++++
 tb/tb_serializer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serializer_if.sv
// Load handshake and serial output bundle shared by the serializer and its frame source.
interface serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PARL_WIDTH = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic                  dir;
    logic [DATA_WIDTH-1:0] par [PARL_WIDTH];
    logic [DATA_WIDTH-1:0] ser;
    logic                  ser_en;
    logic                  busy;
    logic                  done;

    modport master (
        output load_valid, dir, par,
        input  load_ready, ser, ser_en, busy, done
    );

    modport slave (
        input  load_valid, dir, par,
        output load_ready, ser, ser_en, busy, done
    );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter: one PARL_WIDTH-word frame out as one word per clock,
// with gapless back-to-back frames when a new frame is offered on the last beat.
module serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARL_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    serializer_if.slave  bus
);
    localparam int CW = (PARL_WIDTH > 1) ? $clog2(PARL_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(PARL_WIDTH - 1);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(32'd1);

    typedef logic [DATA_WIDTH-1:0] word_t;
    localparam word_t ZERO_W = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    word_t       sh_r    [PARL_WIDTH];
    word_t       sh_s    [PARL_WIDTH];
    word_t       order_s [PARL_WIDTH];
    word_t       ser_r, ser_s;
    logic        ser_en_r, ser_en_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        ready_r, ready_s;
    logic        accept_s;
    logic        load_s;
    logic        clear_s;

    // Offered frame rearranged into transmit order so dir only matters at capture.
    always_comb begin
        for (int i = 0; i < PARL_WIDTH; i++) begin
            if (bus.dir) begin
                order_s[i] = bus.par[PARL_WIDTH-1-i];
            end else begin
                order_s[i] = bus.par[i];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        accept_s = bus.load_valid && ready_r;
        load_s   = 1'b0;
        clear_s  = 1'b0;
        state_s  = state_r;
        cnt_s    = cnt_r;
        ser_s    = ser_r;
        sh_s     = sh_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    clear_s = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_C) begin
                    if (accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        clear_s = 1'b1;
                    end
                end else begin
                    ser_s = sh_r[0];
                    for (int i = 0; i < PARL_WIDTH - 1; i++) begin
                        sh_s[i] = sh_r[i+1];
                    end
                    sh_s[PARL_WIDTH-1] = ZERO_W;
                    cnt_s = cnt_r + ONE_C;
                end
            end
            default: begin
                clear_s = 1'b1;
            end
        endcase

        // The first word goes straight to ser; the rest wait in the shift register.
        if (load_s) begin
            state_s = SHIFT;
            cnt_s   = ZERO_C;
            ser_s   = order_s[0];
            for (int i = 0; i < PARL_WIDTH - 1; i++) begin
                sh_s[i] = order_s[i+1];
            end
            sh_s[PARL_WIDTH-1] = ZERO_W;
        end else if (clear_s) begin
            state_s = IDLE;
            cnt_s   = ZERO_C;
            ser_s   = ZERO_W;
            for (int i = 0; i < PARL_WIDTH; i++) begin
                sh_s[i] = ZERO_W;
            end
        end else begin
            state_s = state_s;
        end

        ser_en_s = (state_s == SHIFT);
        busy_s   = (state_s == SHIFT);
        done_s   = (state_s == SHIFT) && (cnt_s == LAST_C);
        ready_s  = (state_s == IDLE) || (cnt_s == LAST_C);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= ZERO_C;
            for (int i = 0; i < PARL_WIDTH; i++) begin
                sh_r[i] <= ZERO_W;
            end
            ser_r    <= ZERO_W;
            ser_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sh_r     <= sh_s;
            ser_r    <= ser_s;
            ser_en_r <= ser_en_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            ready_r  <= ready_s;
        end
    end

    assign bus.ser        = ser_r;
    assign bus.ser_en     = ser_en_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.load_ready = ready_r;
endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench: accepted frames are queued at the accept edge and a monitor
// checks every output cycle against the frame's word order and handshake rules.
module tb_serializer;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    serializer_if #(.DATA_WIDTH(8), .PARL_WIDTH(4)) b1 ();
    serializer_if #(.DATA_WIDTH(8), .PARL_WIDTH(2)) b2 ();

    serializer #(.DATA_WIDTH(8), .PARL_WIDTH(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    serializer #(.DATA_WIDTH(8), .PARL_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct packed { logic d; logic [3:0][7:0] w; } f4_t;
    typedef struct packed { logic d; logic [1:0][7:0] w; } f2_t;

    f4_t q1[$];
    f2_t q2[$];
    int  k1 = 0;
    int  k2 = 0;
    logic [3:0][7:0] rec1;
    logic [1:0][7:0] rec2;
    bit  drv2_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic cyc1(input logic v, input logic d, input logic [3:0][7:0] w);
        @(negedge clk);
        b1.load_valid = v;
        b1.dir        = d;
        for (int i = 0; i < 4; i++) b1.par[i] = w[i];
    endtask

    task automatic cyc2(input logic v, input logic d, input logic [1:0][7:0] w);
        @(negedge clk);
        b2.load_valid = v;
        b2.dir        = d;
        for (int i = 0; i < 2; i++) b2.par[i] = w[i];
    endtask

    // Model capture: a frame is taken exactly when valid meets ready at the edge.
    always @(posedge clk) begin : push
        f4_t n1;
        f2_t n2;
        if (!rst && b1.load_valid && b1.load_ready) begin
            n1.d = b1.dir;
            for (int i = 0; i < 4; i++) n1.w[i] = b1.par[i];
            q1.push_back(n1);
        end
        if (!rst && b2.load_valid && b2.load_ready) begin
            n2.d = b2.dir;
            for (int i = 0; i < 2; i++) n2.w[i] = b2.par[i];
            q2.push_back(n2);
        end
    end

    always @(negedge clk) begin : mon1
        f4_t f;
        int  idx;
        if (rst) begin
            chk("rst_ser1", 32'(b1.ser), 32'd0);
            chk("rst_en1", 32'(b1.ser_en), 32'd0);
            chk("rst_busy1", 32'(b1.busy), 32'd0);
            chk("rst_done1", 32'(b1.done), 32'd0);
            q1.delete();
            k1 = 0;
        end else if (q1.size() == 0) begin
            chk("idle_en1", 32'(b1.ser_en), 32'd0);
            chk("idle_ser1", 32'(b1.ser), 32'd0);
            chk("idle_busy1", 32'(b1.busy), 32'd0);
            chk("idle_done1", 32'(b1.done), 32'd0);
            chk("idle_ready1", 32'(b1.load_ready), 32'd1);
        end else begin
            f   = q1[0];
            idx = f.d ? 3 - k1 : k1;
            chk("ser1", 32'(b1.ser), 32'(f.w[idx]));
            chk("en1", 32'(b1.ser_en), 32'd1);
            chk("busy1", 32'(b1.busy), 32'd1);
            chk("done1", 32'(b1.done), 32'(k1 == 3));
            chk("ready1", 32'(b1.load_ready), 32'(k1 == 3));
            // A receiver with the same dir files beat k at this index.
            rec1[idx] = b1.ser;
            k1++;
            if (k1 == 4) begin
                chk("recover1", rec1, f.w);
                void'(q1.pop_front());
                k1 = 0;
            end
        end
    end

    always @(negedge clk) begin : mon2
        f2_t f;
        int  idx;
        if (rst) begin
            chk("rst_ser2", 32'(b2.ser), 32'd0);
            chk("rst_en2", 32'(b2.ser_en), 32'd0);
            chk("rst_done2", 32'(b2.done), 32'd0);
            q2.delete();
            k2 = 0;
        end else if (q2.size() == 0) begin
            chk("idle_en2", 32'(b2.ser_en), 32'd0);
            chk("idle_ser2", 32'(b2.ser), 32'd0);
            chk("idle_ready2", 32'(b2.load_ready), 32'd1);
        end else begin
            f   = q2[0];
            idx = f.d ? 1 - k2 : k2;
            chk("ser2", 32'(b2.ser), 32'(f.w[idx]));
            chk("en2", 32'(b2.ser_en), 32'd1);
            chk("busy2", 32'(b2.busy), 32'd1);
            chk("done2", 32'(b2.done), 32'(k2 == 1));
            chk("ready2", 32'(b2.load_ready), 32'(k2 == 1));
            rec2[idx] = b2.ser;
            k2++;
            if (k2 == 2) begin
                chk("recover2", 32'(rec2), 32'(f.w));
                void'(q2.pop_front());
                k2 = 0;
            end
        end
    end

    // Narrow instance: continuous load_valid, first a fixed frame, then random frames.
    initial begin : drv2
        logic [1:0][7:0] w;
        wait (rst == 1'b0);
        w = {8'hA5, 8'h5A};
        repeat (40) cyc2(1'b1, 1'b0, w);
        repeat (100) begin
            w = {8'($urandom), 8'($urandom)};
            cyc2(1'b1, 1'($urandom_range(0, 1)), w);
        end
        cyc2(1'b0, 1'b0, w);
        drv2_done = 1'b1;
    end

    initial begin : main
        logic [3:0][7:0] f1, f2, f3, w;
        f1 = {8'h44, 8'h33, 8'h22, 8'h11};
        f2 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        f3 = {8'h0F, 8'hE7, 8'h3C, 8'h96};
        w  = '0;
        rst = 1'b1;
        b1.load_valid = 1'b0;
        b1.dir = 1'b0;
        for (int i = 0; i < 4; i++) b1.par[i] = 8'h00;
        b2.load_valid = 1'b0;
        b2.dir = 1'b0;
        for (int i = 0; i < 2; i++) b2.par[i] = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        cyc1(1'b1, 1'b0, f1);
        cyc1(1'b0, 1'b0, f1);
        repeat (6) cyc1(1'b0, 1'b0, w);

        cyc1(1'b1, 1'b1, f1);
        cyc1(1'b0, 1'b0, f1);
        repeat (6) cyc1(1'b0, 1'b0, w);

        // Second frame held until the last-beat edge of the first: 8 gapless beats.
        cyc1(1'b1, 1'b0, f1);
        repeat (4) cyc1(1'b1, 1'b0, f2);
        cyc1(1'b0, 1'b0, w);
        repeat (8) cyc1(1'b0, 1'b0, w);

        // par/dir swapped while the first frame is still shifting.
        cyc1(1'b1, 1'b0, f1);
        cyc1(1'b1, 1'b0, f1);
        repeat (3) cyc1(1'b1, 1'b1, f3);
        cyc1(1'b0, 1'b0, w);
        repeat (8) cyc1(1'b0, 1'b0, w);

        // Asynchronous reset mid-frame, with load_valid raised while in reset.
        cyc1(1'b1, 1'b0, f2);
        cyc1(1'b0, 1'b0, f2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ser", 32'(b1.ser), 32'd0);
        chk("async_en", 32'(b1.ser_en), 32'd0);
        chk("async_busy", 32'(b1.busy), 32'd0);
        chk("async_done", 32'(b1.done), 32'd0);
        b1.load_valid = 1'b1;
        repeat (2) @(negedge clk);
        b1.load_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        cyc1(1'b1, 1'b1, f1);
        cyc1(1'b0, 1'b0, f1);
        repeat (6) cyc1(1'b0, 1'b0, w);

        repeat (300) begin
            for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
            cyc1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), w);
        end
        cyc1(1'b0, 1'b0, w);

        for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0 || !drv2_done); i++) begin
            @(negedge clk);
        end
        chk("drain", 32'(q1.size() + q2.size()), 32'd0);
        chk("drv2_done", 32'(drv2_done), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
